posit_decoder_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined posit decoder with valid/ready flow control.

---
 rtl/posit_decoder_pipe_if.sv | 30 +++
 rtl/posit_decoder_pipe.sv | 143 ++++++++++++++
 tb/tb_posit_decoder_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_decoder_pipe_if.sv
// Stream bundle for the posit decoder: posit input handshake plus decoded-field output handshake.
// The decoder takes the slave modport; the producer/consumer side takes master.
interface posit_decoder_pipe_if #(
  parameter int N  = 8,
  parameter int ES = 0
);
  localparam int FW = N - 3 - ES;
  localparam int SW = $clog2((N - 1) << ES) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_posit;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic          out_zero;
  logic          out_inf;
  logic [SW-1:0] out_scale;
  logic [FW-1:0] out_frac;

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_frac
  );

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_frac
  );
endinterface

// File: rtl/posit_decoder_pipe.sv
// Two-stage posit decoder: stage 1 takes sign/special flags and magnitude, stage 2 splits regime/exponent/fraction.
// Optional NaR output counter enabled by defining POSIT_DEC_NAR_CNT_EN.
module posit_decoder_pipe #(
  parameter int N  = 8,
  parameter int ES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  posit_decoder_pipe_if.slave bus
`ifdef POSIT_DEC_NAR_CNT_EN
  ,
  output logic [15:0]         nar_count
`endif
);
  localparam int FW = N - 3 - ES;
  localparam int SW = $clog2((N - 1) << ES) + 1;
  localparam int CW = $clog2(N);

  logic          s1_valid_reg, s1_sign_reg, s1_zero_reg, s1_inf_reg;
  logic [N-2:0]  s1_mag_reg;
  logic          out_valid_reg, out_sign_reg, out_zero_reg, out_inf_reg;
  logic [SW-1:0] out_scale_reg;
  logic [FW-1:0] out_frac_reg;

  logic          s1_adv, s2_adv;
  logic          s1_zero_next, s1_inf_next;
  logic [N-2:0]  s1_mag_next;

  assign s2_adv       = ~out_valid_reg | bus.out_ready;
  assign s1_adv       = ~s1_valid_reg | s2_adv;
  assign bus.in_ready = s1_adv;

  // The top magnitude bit is only set for NaR, which is flagged separately, so it is not stored.
  assign s1_zero_next = (bus.in_posit == '0);
  assign s1_inf_next  = (bus.in_posit == {1'b1, {(N-1){1'b0}}});
  assign s1_mag_next  = bus.in_posit[N-1] ? (~bus.in_posit[N-2:0] + 1'b1) : bus.in_posit[N-2:0];

  logic          regime_bit;
  logic [N-3:0]  diff;
  logic [CW-1:0] run_len_next;
  logic [CW-1:0] shamt;
  logic [N-4:0]  rem;
  logic [ES:0]   exp_ext;
  logic [SW-1:0] k_val;
  logic [SW-1:0] scale_next;
  logic [FW-1:0] frac_next;

  assign regime_bit = s1_mag_reg[N-2];

  genvar gi;
  generate
    for (gi = 0; gi <= N - 3; gi++) begin : g_diff
      assign diff[gi] = s1_mag_reg[gi] ^ regime_bit;
    end
  endgenerate

  // Highest bit that differs from the regime bit is the terminator; none means the run reaches bit 0.
  always_comb begin
    run_len_next = CW'(N - 1);
    for (int i = 0; i <= N - 3; i++) begin
      if (diff[i]) run_len_next = CW'(N - 2 - i);
    end
  end

  // Run length is at least 1, so the top two magnitude bits are always regime/terminator bits.
  assign shamt = run_len_next - CW'(1);
  assign rem   = s1_mag_reg[N-4:0] << shamt;

  generate
    if (ES > 0) begin : g_exp
      assign exp_ext = {1'b0, rem[N-4 -: ES]};
    end else begin : g_no_exp
      assign exp_ext = 1'b0;
    end
  endgenerate

  always_comb begin
    k_val      = regime_bit ? (SW'(run_len_next) - SW'(1)) : -SW'(run_len_next);
    scale_next = (k_val << ES) | SW'(exp_ext);
    frac_next  = rem[FW-1:0];
    if (s1_zero_reg | s1_inf_reg) begin
      scale_next = '0;
      frac_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_inf_reg    <= 1'b0;
      s1_mag_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_sign_reg  <= 1'b0;
      out_zero_reg  <= 1'b0;
      out_inf_reg   <= 1'b0;
      out_scale_reg <= '0;
      out_frac_reg  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign_reg <= bus.in_posit[N-1];
          s1_zero_reg <= s1_zero_next;
          s1_inf_reg  <= s1_inf_next;
          s1_mag_reg  <= s1_mag_next;
        end
      end
      if (s2_adv) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_sign_reg  <= s1_sign_reg;
          out_zero_reg  <= s1_zero_reg;
          out_inf_reg   <= s1_inf_reg;
          out_scale_reg <= scale_next;
          out_frac_reg  <= frac_next;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_sign  = out_sign_reg;
  assign bus.out_zero  = out_zero_reg;
  assign bus.out_inf   = out_inf_reg;
  assign bus.out_scale = out_scale_reg;
  assign bus.out_frac  = out_frac_reg;

`ifdef POSIT_DEC_NAR_CNT_EN
  logic [15:0] nar_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nar_count_reg <= '0;
    end else if (out_valid_reg && bus.out_ready && out_inf_reg && (nar_count_reg != 16'hFFFF)) begin
      nar_count_reg <= nar_count_reg + 16'd1;
    end
  end

  assign nar_count = nar_count_reg;
`endif
endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Scoreboard bench for posit_decoder_pipe: an N=8/ES=0 instance with directed vectors and an N=16/ES=2
// instance with directed vectors plus a random stream checked against a bit-serial reference decoder.
module tb_posit_decoder_pipe;
  typedef struct {
    logic [15:0] p;
    logic        sign;
    logic        zero;
    logic        inf;
    int          scale;
    logic [15:0] frac;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  posit_decoder_pipe_if #(.N(8),  .ES(0)) bus8 ();
  posit_decoder_pipe_if #(.N(16), .ES(2)) bus16 ();

`ifdef POSIT_DEC_NAR_CNT_EN
  logic [15:0] nar_count8, nar_count16;
`endif

  posit_decoder_pipe #(.N(8), .ES(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
`ifdef POSIT_DEC_NAR_CNT_EN
    , .nar_count(nar_count8)
`endif
  );

  posit_decoder_pipe #(.N(16), .ES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
`ifdef POSIT_DEC_NAR_CNT_EN
    , .nar_count(nar_count16)
`endif
  );

  exp_t q8[$];
  exp_t q16[$];
  int compared = 0;
  int mismatched = 0;
  int nar8_exp = 0;
  int nar16_exp = 0;
  bit rand_done = 0;

  function automatic exp_t mk(logic [15:0] p, logic s, logic z, logic i, int sc, logic [15:0] f);
    exp_t e;
    e.p = p; e.sign = s; e.zero = z; e.inf = i; e.scale = sc; e.frac = f;
    return e;
  endfunction

  // Bit-serial reference for N=16, ES=2: walk the magnitude one bit at a time.
  function automatic exp_t ref16(logic [15:0] p);
    exp_t e;
    logic [15:0] m;
    logic r;
    int i, run, k, ex, fr;
    e = mk(p, p[15], p == 16'h0000, p == 16'h8000, 0, 16'h0);
    if (e.zero || e.inf) return e;
    m = p[15] ? -p : p;
    r = m[14];
    i = 14;
    run = 0;
    while (i >= 0 && m[i] == r) begin run++; i--; end
    k = r ? run - 1 : -run;
    i--;
    ex = 0;
    repeat (2) begin ex = ex * 2 + ((i >= 0) ? int'(m[i]) : 0); i--; end
    fr = 0;
    repeat (11) begin fr = fr * 2 + ((i >= 0) ? int'(m[i]) : 0); i--; end
    e.scale = k * 4 + ex;
    e.frac  = fr[15:0];
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e, input logic s, input logic z,
                           input logic i, input int sc, input logic [15:0] f);
    compared++;
    if (s !== e.sign || z !== e.zero || i !== e.inf || sc != e.scale || f !== e.frac) begin
      mismatched++;
      $display("FAIL %s p=%h: got s=%0d z=%0d i=%0d sc=%0d f=%h, required s=%0d z=%0d i=%0d sc=%0d f=%h",
               tag, e.p, s, z, i, sc, f, e.sign, e.zero, e.inf, e.scale, e.frac);
    end else begin
      $display("%s p=%h s=%0d z=%0d i=%0d sc=%0d f=%h ok", tag, e.p, s, z, i, sc, f);
    end
  endtask

  // Output monitors: hold check while stalled, then scoreboard pop on each transfer.
  logic        hold8 = 0, hold16 = 0;
  logic [31:0] prev8, prev16;

  always @(negedge clk) begin : mon8
    exp_t e;
    logic [31:0] cur;
    cur = {20'h0, bus8.out_sign, bus8.out_zero, bus8.out_inf, bus8.out_scale, bus8.out_frac};
    if (!rst_n) begin
      hold8 = 0;
      nar8_exp = 0;
    end else begin
      if (hold8) begin
        compared++;
        if (!bus8.out_valid || cur !== prev8) begin
          mismatched++;
          $display("FAIL hold8: got valid=%0d data=%h, required valid=1 data=%h", bus8.out_valid, cur, prev8);
        end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected8: got an output, required none");
        end else begin
          e = q8.pop_front();
          if (e.inf) nar8_exp++;
          check_out("txn8", e, bus8.out_sign, bus8.out_zero, bus8.out_inf,
                    int'($signed(bus8.out_scale)), 16'(bus8.out_frac));
        end
      end
      hold8 = bus8.out_valid && !bus8.out_ready;
      prev8 = cur;
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    logic [31:0] cur;
    cur = {11'h0, bus16.out_sign, bus16.out_zero, bus16.out_inf, bus16.out_scale, bus16.out_frac};
    if (!rst_n) begin
      hold16 = 0;
      nar16_exp = 0;
    end else begin
      if (hold16) begin
        compared++;
        if (!bus16.out_valid || cur !== prev16) begin
          mismatched++;
          $display("FAIL hold16: got valid=%0d data=%h, required valid=1 data=%h", bus16.out_valid, cur, prev16);
        end
      end
      if (bus16.out_valid && bus16.out_ready) begin
        if (q16.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected16: got an output, required none");
        end else begin
          e = q16.pop_front();
          if (e.inf) nar16_exp++;
          check_out("txn16", e, bus16.out_sign, bus16.out_zero, bus16.out_inf,
                    int'($signed(bus16.out_scale)), 16'(bus16.out_frac));
        end
      end
      hold16 = bus16.out_valid && !bus16.out_ready;
      prev16 = cur;
    end
  end

  // Drivers: called just after a rising edge; return just after the accepting edge.
  task automatic send8(input logic [7:0] p, input exp_t e);
    bit done = 0;
    bus8.in_valid = 1'b1;
    bus8.in_posit = p;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus8.in_ready) begin q8.push_back(e); done = 1; end
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    if (!done) begin
      compared++; mismatched++;
      $display("FAIL send8_timeout p=%h: got in_ready=0 for 100 cycles, required 1", p);
    end
  endtask

  task automatic send16(input logic [15:0] p, input exp_t e);
    bit done = 0;
    bus16.in_valid = 1'b1;
    bus16.in_posit = p;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus16.in_ready) begin q16.push_back(e); done = 1; end
      @(posedge clk); #1;
    end
    bus16.in_valid = 1'b0;
    if (!done) begin
      compared++; mismatched++;
      $display("FAIL send16_timeout p=%h: got in_ready=0 for 100 cycles, required 1", p);
    end
  endtask

  task automatic drain();
    bit empty = 0;
    for (int c = 0; c < 500 && !empty; c++) begin
      @(negedge clk);
      empty = (q8.size() == 0) && (q16.size() == 0);
    end
    if (!empty) begin
      compared++; mismatched++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", q8.size(), q16.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus8.in_valid = 0;  bus8.in_posit = '0;  bus8.out_ready = 1;
    bus16.in_valid = 0; bus16.in_posit = '0; bus16.out_ready = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid8", int'(bus8.out_valid), 0);
    chk("reset_data8", int'({bus8.out_sign, bus8.out_zero, bus8.out_inf, bus8.out_scale, bus8.out_frac}), 0);
    chk("reset_out_valid16", int'(bus16.out_valid), 0);
`ifdef POSIT_DEC_NAR_CNT_EN
    chk("reset_nar_count8", int'(nar_count8), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready8", int'(bus8.in_ready), 1);
    chk("post_reset_in_ready16", int'(bus16.in_ready), 1);
    @(posedge clk); #1;

    // Basic regime/fraction patterns, back to back
    send8(8'h40, mk(16'h40, 0, 0, 0,  0, 16'h00));
    send8(8'h60, mk(16'h60, 0, 0, 0,  1, 16'h00));
    send8(8'h50, mk(16'h50, 0, 0, 0,  0, 16'h10));
    send8(8'h20, mk(16'h20, 0, 0, 0, -1, 16'h00));
    // Range extremes and specials
    send8(8'h7F, mk(16'h7F, 0, 0, 0,  6, 16'h00));
    send8(8'h01, mk(16'h01, 0, 0, 0, -6, 16'h00));
    send8(8'h00, mk(16'h00, 0, 1, 0,  0, 16'h00));
    send8(8'h80, mk(16'h80, 1, 0, 1,  0, 16'h00));
    // Negative posits
    send8(8'hC0, mk(16'hC0, 1, 0, 0,  0, 16'h00));
    send8(8'hB0, mk(16'hB0, 1, 0, 0,  0, 16'h10));
    drain();

    // Backpressure: consumer stalls while three posits are offered
    bus8.out_ready = 0;
    fork
      begin
        send8(8'h40, mk(16'h40, 0, 0, 0, 0, 16'h00));
        send8(8'h60, mk(16'h60, 0, 0, 0, 1, 16'h00));
        send8(8'h50, mk(16'h50, 0, 0, 0, 0, 16'h10));
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_in_ready8", int'(bus8.in_ready), 0);
        chk("stall_queued8", q8.size(), 2);
        repeat (3) @(posedge clk);
        #1 bus8.out_ready = 1;
      end
    join
    drain();

    // Reset with two posits in flight
    bus8.out_ready = 0;
    send8(8'h40, mk(16'h40, 0, 0, 0, 0, 16'h00));
    send8(8'h60, mk(16'h60, 0, 0, 0, 1, 16'h00));
    rst_n = 1'b0;
    q8.delete();
    q16.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_out_valid8", int'(bus8.out_valid), 0);
    chk("flush_in_ready8", int'(bus8.in_ready), 1);
    @(posedge clk); #1;
    bus8.out_ready = 1;
    bus8.in_valid = 1;
    bus8.in_posit = 8'h60;
    q8.push_back(mk(16'h60, 0, 0, 0, 1, 16'h00));
    @(negedge clk);
    chk("lat_in_ready8", int'(bus8.in_ready), 1);
    @(posedge clk); #1;
    bus8.in_valid = 0;
    @(negedge clk);
    chk("lat_cycle1_valid8", int'(bus8.out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2_valid8", int'(bus8.out_valid), 1);
    @(posedge clk); #1;
    drain();

    // N=16, ES=2 directed: 0x5A00 has k=0, e=3; 0x6400 has k=1, e=1
    send16(16'h5A00, mk(16'h5A00, 0, 0, 0,   3, 16'h200));
    send16(16'h6400, mk(16'h6400, 0, 0, 0,   5, 16'h000));
    send16(16'h7FFF, mk(16'h7FFF, 0, 0, 0,  56, 16'h000));
    send16(16'h0001, mk(16'h0001, 0, 0, 0, -56, 16'h000));
    send16(16'hFFFF, mk(16'hFFFF, 1, 0, 0, -56, 16'h000));
    send16(16'h8000, mk(16'h8000, 1, 0, 1,   0, 16'h000));
    send16(16'h0000, mk(16'h0000, 0, 1, 0,   0, 16'h000));
    drain();

    // Random stream with random consumer stalls
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          logic [15:0] p;
          p = 16'($urandom);
          case ($urandom_range(0, 31))
            0: p = 16'h8000;
            1: p = 16'h0000;
            default: ;
          endcase
          send16(p, ref16(p));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus16.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus16.out_ready = 1;
      end
    join
    drain();

`ifdef POSIT_DEC_NAR_CNT_EN
    chk("nar_count8", int'(nar_count8), nar8_exp);
    chk("nar_count16", int'(nar_count16), nar16_exp);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
